// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : pipe_hazard_ctrl_if
// Description : Decode/execute side bundle of the pipeline hazard controller:
//               decode operand info, branch/busy status in; stall, bubble,
//               flush, forwarding selects and statistics out.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
);
  localparam int NSLOTS = STAGES - 2;
  localparam int SEL_W  = $clog2(NSLOTS + 1);

  logic              dec_valid;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic              dec_rs1_used;
  logic              dec_rs2_used;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_wb;
  logic              dec_ld;
  logic              br_taken;
  logic              ex_busy;

  logic              stall_f;
  logic              stall_d;
  logic              bubble_e;
  logic              flush_fd;
  logic              flush_de;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic [SEL_W-1:0]  occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Pipeline side: presents decode/execute status, consumes controls.
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_wb, dec_ld, br_taken, ex_busy,
    input  stall_f, stall_d, bubble_e, flush_fd, flush_de,
           fwd_sel1, fwd_sel2, occupancy, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_wb, dec_ld, br_taken, ex_busy,
    output stall_f, stall_d, bubble_e, flush_fd, flush_de,
           fwd_sel1, fwd_sel2, occupancy, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : pipe_hazard_ctrl
// Description : Hazard, stall and flush controller for in-order pipelines of
//               3..8 stages. Tracks in-flight register writers from execute
//               to writeback in a slot shift register.
//               Optional feature macro HZ_FWD_EN: operand forwarding with
//               load-use detection; without it any RAW match stalls.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW = 4,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int NSLOTS = STAGES - 2;
  localparam int SEL_W  = $clog2(NSLOTS + 1);

  // Slot 0 is execute, slot NSLOTS-1 is writeback.
  logic [NSLOTS-1:0] r_valid;
  logic [NSLOTS-1:0] r_wb;
  logic [REG_AW-1:0] r_rd [NSLOTS];
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [NSLOTS-1:0] w_m1;
  logic [NSLOTS-1:0] w_m2;
  logic              w_hazard;
  logic [SEL_W-1:0]  w_sel1;
  logic [SEL_W-1:0]  w_sel2;
  logic [SEL_W-1:0]  w_occ;
  logic              w_busy;
  logic              w_br;
  logic              w_hz;

  // Per-slot operand matches; the writeback slot counts because the
  // register file does not bypass a same-edge write.
  generate
    for (genvar s = 0; s < NSLOTS; s++) begin : g_match
      assign w_m1[s] = r_valid[s] & r_wb[s] & (r_rd[s] == hz.dec_rs1)
                     & hz.dec_rs1_used & hz.dec_valid;
      assign w_m2[s] = r_valid[s] & r_wb[s] & (r_rd[s] == hz.dec_rs2)
                     & hz.dec_rs2_used & hz.dec_valid;
    end
  endgenerate

`ifdef HZ_FWD_EN
  logic [NSLOTS-1:0] r_ld;

  // Youngest (lowest index) matching slot wins the forwarding select.
  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    for (int s = NSLOTS - 1; s >= 0; s--) begin
      if (w_m1[s]) w_sel1 = SEL_W'(s + 1);
      if (w_m2[s]) w_sel2 = SEL_W'(s + 1);
    end
  end

  // Only a load still in execute cannot be forwarded in time.
  assign w_hazard = (w_m1[0] | w_m2[0]) & r_ld[0];

  // Load flag travels with its slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld <= '0;
    end else if (!hz.ex_busy) begin
      for (int s = NSLOTS - 1; s > 0; s--) r_ld[s] <= r_ld[s-1];
      r_ld[0] <= hz.dec_ld;
    end
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = hz.dec_ld;
  assign w_sel1      = '0;
  assign w_sel2      = '0;
  assign w_hazard    = (|w_m1) | (|w_m2);
`endif

  // Priority: busy freezes everything, then a taken branch, then hazard.
  assign w_busy = hz.ex_busy;
  assign w_br   = ~w_busy & hz.br_taken;
  assign w_hz   = ~w_busy & ~hz.br_taken & w_hazard;

  // Count of live slots.
  always_comb begin
    w_occ = '0;
    for (int s = 0; s < NSLOTS; s++) w_occ = w_occ + SEL_W'(r_valid[s]);
  end

  // Slot shift register and saturating statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      for (int s = 0; s < NSLOTS; s++) r_rd[s] <= '0;
    end else if (!w_busy) begin
      for (int s = NSLOTS - 1; s > 0; s--) begin
        r_valid[s] <= r_valid[s-1];
        r_wb[s]    <= r_wb[s-1];
        r_rd[s]    <= r_rd[s-1];
      end
      // A killed or stalled decode instruction enters execute as a bubble.
      r_valid[0] <= hz.dec_valid & ~hz.br_taken & ~w_hazard;
      r_wb[0]    <= hz.dec_wb;
      r_rd[0]    <= hz.dec_rd;
      if (w_br) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_hz) begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Controls are forced low while reset is held, whatever the inputs do.
  assign hz.stall_f   = reset & (w_busy | w_hz);
  assign hz.stall_d   = reset & (w_busy | w_hz);
  assign hz.bubble_e  = reset & w_hz;
  assign hz.flush_fd  = reset & w_br;
  assign hz.flush_de  = reset & w_br;
  assign hz.fwd_sel1  = (reset & ~w_hazard) ? w_sel1 : '0;
  assign hz.fwd_sel2  = (reset & ~w_hazard) ? w_sel2 : '0;
  assign hz.occupancy = w_occ;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl with a
//               4-stage and an 8-stage (2-bit counter) instance.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11100;
  localparam logic [4:0] C_FLUSH = 5'b00011;
  localparam logic [4:0] C_BUSY  = 5'b11000;
`ifdef HZ_FWD_EN
  localparam int C_SCNT_A = 0;
`else
  localparam int C_SCNT_A = 2;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_chk;
  int   n_pass;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(4), .STAGES(4), .CNT_W(16)) p4 ();
  pipe_hazard_ctrl_if #(.REG_AW(4), .STAGES(8), .CNT_W(2))  p8 ();

  pipe_hazard_ctrl #(.REG_AW(4), .STAGES(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .reset(reset), .hz(p4)
  );
  pipe_hazard_ctrl #(.REG_AW(4), .STAGES(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .reset(reset), .hz(p8)
  );

  logic [4:0] ctl4;
  logic [4:0] ctl8;
  assign ctl4 = {p4.stall_f, p4.stall_d, p4.bubble_e, p4.flush_fd, p4.flush_de};
  assign ctl8 = {p8.stall_f, p8.stall_d, p8.bubble_e, p8.flush_fd, p8.flush_de};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic dec4(input logic v, input logic [3:0] r1, input logic u1,
                      input logic [3:0] r2, input logic u2,
                      input logic [3:0] rd, input logic wb, input logic ld);
    p4.dec_valid = v;  p4.dec_rs1 = r1; p4.dec_rs1_used = u1;
    p4.dec_rs2   = r2; p4.dec_rs2_used = u2;
    p4.dec_rd    = rd; p4.dec_wb = wb; p4.dec_ld = ld;
  endtask

  task automatic dec8(input logic v, input logic [3:0] r1, input logic u1,
                      input logic [3:0] r2, input logic u2,
                      input logic [3:0] rd, input logic wb, input logic ld);
    p8.dec_valid = v;  p8.dec_rs1 = r1; p8.dec_rs1_used = u1;
    p8.dec_rs2   = r2; p8.dec_rs2_used = u2;
    p8.dec_rd    = rd; p8.dec_wb = wb; p8.dec_ld = ld;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    dec4(0, 0, 0, 0, 0, 0, 0, 0);
    dec8(0, 0, 0, 0, 0, 0, 0, 0);
    p4.br_taken = 1'b1; p4.ex_busy = 1'b1;
    p8.br_taken = 1'b0; p8.ex_busy = 1'b1;
    #2;
    chk("rst_ctl4", 32'(ctl4), 32'(C_NONE));
    chk("rst_ctl8", 32'(ctl8), 32'(C_NONE));
    chk("rst_occ4", 32'(p4.occupancy), 32'd0);
    p4.br_taken = 1'b0; p4.ex_busy = 1'b0; p8.ex_busy = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_cnt4", 32'({p4.stall_cnt, p4.flush_cnt}), 32'd0);

    // add r3 followed by sub r5,r3,r1
    dec4(1, 0, 0, 0, 0, 3, 1, 0); #1;
    chk("add_ctl", 32'(ctl4), 32'(C_NONE));
    tick();
    dec4(1, 3, 1, 1, 1, 5, 1, 0); #1;
`ifndef HZ_FWD_EN
    chk("raw_s0_ctl", 32'(ctl4), 32'(C_STALL));
    chk("raw_s0_occ", 32'(p4.occupancy), 32'd1);
    tick(); #1;
    chk("raw_s1_ctl", 32'(ctl4), 32'(C_STALL));
    chk("raw_s1_scnt", 32'(p4.stall_cnt), 32'd1);
    tick(); #1;
    chk("raw_go_ctl", 32'(ctl4), 32'(C_NONE));
    chk("raw_go_scnt", 32'(p4.stall_cnt), 32'd2);
    chk("raw_go_occ", 32'(p4.occupancy), 32'd0);
    tick();
    chk("raw_issue_occ", 32'(p4.occupancy), 32'd1);
`else
    chk("fwd_ctl", 32'(ctl4), 32'(C_NONE));
    chk("fwd_sel1", 32'(p4.fwd_sel1), 32'd1);
    chk("fwd_sel2", 32'(p4.fwd_sel2), 32'd0);
    tick();
    chk("fwd_occ", 32'(p4.occupancy), 32'd2);
`endif

    // Taken branch with a dependent instruction in decode
    dec4(1, 5, 1, 3, 1, 6, 1, 0);
    p4.br_taken = 1'b1; #1;
    chk("br_ctl", 32'(ctl4), 32'(C_FLUSH));
`ifdef HZ_FWD_EN
    chk("br_sel1", 32'(p4.fwd_sel1), 32'd1);
    chk("br_sel2", 32'(p4.fwd_sel2), 32'd2);
`endif
    tick();
    p4.br_taken = 1'b0;
    dec4(1, 6, 1, 0, 0, 7, 1, 0); #1;
    chk("br_after_ctl", 32'(ctl4), 32'(C_NONE));
    chk("br_after_occ", 32'(p4.occupancy), 32'd1);
    chk("br_fcnt", 32'(p4.flush_cnt), 32'd1);
    chk("br_scnt", 32'(p4.stall_cnt), 32'(C_SCNT_A));
    tick();

    // ex_busy for 5 cycles with br_taken asserted
    p4.ex_busy = 1'b1; p4.br_taken = 1'b1;
    dec4(1, 7, 1, 0, 0, 8, 1, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("busy_ctl", 32'(ctl4), 32'(C_BUSY));
      chk("busy_occ", 32'(p4.occupancy), 32'd1);
      tick();
    end
    chk("busy_scnt", 32'(p4.stall_cnt), 32'(C_SCNT_A));
    chk("busy_fcnt", 32'(p4.flush_cnt), 32'd1);
    p4.ex_busy = 1'b0; p4.br_taken = 1'b0;
    dec4(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("unbusy_ctl", 32'(ctl4), 32'(C_NONE));
    tick();
    chk("unbusy_occ", 32'(p4.occupancy), 32'd1);
    tick();

    // ld r4 followed by use of r4 in rs2
    dec4(1, 0, 0, 0, 0, 4, 1, 1); #1;
    chk("ld_ctl", 32'(ctl4), 32'(C_NONE));
    tick();
    dec4(1, 0, 0, 4, 1, 9, 1, 0); #1;
    chk("ldu_ctl1", 32'(ctl4), 32'(C_STALL));
    tick(); #1;
`ifdef HZ_FWD_EN
    chk("ldu_go_ctl", 32'(ctl4), 32'(C_NONE));
    chk("ldu_sel2", 32'(p4.fwd_sel2), 32'd2);
    chk("ldu_scnt", 32'(p4.stall_cnt), 32'd1);
`else
    chk("ldu_ctl2", 32'(ctl4), 32'(C_STALL));
    chk("ldu_scnt", 32'(p4.stall_cnt), 32'd3);
    tick(); #1;
    chk("ldu_go_ctl", 32'(ctl4), 32'(C_NONE));
    chk("ldu_go_scnt", 32'(p4.stall_cnt), 32'd4);
`endif
    tick();
    dec4(0, 0, 0, 0, 0, 0, 0, 0);

    // 8-stage: writer then reader, counter saturation at 2 bits
    dec8(1, 0, 0, 0, 0, 9, 1, 0); #1;
    chk("w8_ctl", 32'(ctl8), 32'(C_NONE));
    tick();
    dec8(1, 0, 0, 9, 1, 12, 1, 0);
`ifndef HZ_FWD_EN
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("raw8_ctl", 32'(ctl8), 32'(C_STALL));
      tick();
    end
    #1;
    chk("raw8_go_ctl", 32'(ctl8), 32'(C_NONE));
    chk("raw8_sat", 32'(p8.stall_cnt), 32'd3);
`else
    #1;
    chk("fwd8_ctl", 32'(ctl8), 32'(C_NONE));
    chk("fwd8_sel2", 32'(p8.fwd_sel2), 32'd1);
    chk("fwd8_scnt", 32'(p8.stall_cnt), 32'd0);
`endif
    tick();

    // 8-stage: load then user, reset asserted while stalled
    dec8(1, 0, 0, 0, 0, 10, 1, 1); #1;
    tick();
    dec8(1, 10, 1, 0, 0, 11, 1, 0); #1;
    chk("ldu8_ctl", 32'(ctl8), 32'(C_STALL));
    reset = 1'b0; #1;
    chk("rst8_ctl", 32'(ctl8), 32'(C_NONE));
    chk("rst8_occ", 32'(p8.occupancy), 32'd0);
    chk("rst8_cnt", 32'({p8.stall_cnt, p8.flush_cnt}), 32'd0);
    chk("rst8_ctl4", 32'(ctl4), 32'(C_NONE));
    tick();
    reset = 1'b1; #1;
    chk("post8_ctl", 32'(ctl8), 32'(C_NONE));
    chk("post8_occ0", 32'(p8.occupancy), 32'd0);
    tick();
    chk("post8_occ1", 32'(p8.occupancy), 32'd1);
    chk("post8_scnt", 32'(p8.stall_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
